xc_sha3_idx_seq: RTL and testbench
==================================

Name: xc_sha3_idx_seq

Overview:
- Sequential, parametrised successor to the single-shot SHA3 lane-index function. One request sweeps all 25 Keccak lane coordinates (x,y).
- Each output beat is a lane address: base + (index << shamt). The index is computed under the selected mode: xy, x1, x2, x4 or yx (pi).
- Sits beside the Keccak load/store datapath and drives lane fetch/writeback addresses through a valid/ready stream. This removes per-lane index instructions from software loops.

Parameters:
- ADDR_W, 32, width of base and output address; address arithmetic wraps modulo 2^ADDR_W.
- SHAMT_W, 2, width of the shamt field; shift range is 0 to 2^SHAMT_W-1.

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_rst  in  1  synchronous, active-high reset.
- req_valid  in  1  start request.
- req_ready  out  1  block idle and able to accept a request.
- req_base  in  ADDR_W  base address of the lane array.
- req_mode  in  3  0=xy, 1=x1, 2=x2, 3=x4, 4=yx; values 5-7 are treated as xy.
- req_shamt  in  SHAMT_W  post-shift applied to the lane index.
- abort  in  1  synchronous cancel of the current sweep.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_addr  out  ADDR_W  lane address.
- out_x  out  3  current x (0-4).
- out_y  out  3  current y (0-4).
- out_last  out  1  high on the 25th beat (x=4, y=4).
- busy  out  1  sweep in progress (state RUN).

Behaviour:
- Reset is synchronous and active-high. While g_rst is high on a clock edge:
  - state goes to IDLE; out_valid=0, out_addr=0, out_x=0, out_y=0, out_last=0, busy=0.
  - base, mode and shamt registers clear to 0.
  - req_ready is 1 in the first cycle after reset deasserts.
- State IDLE:
  - req_ready=1, out_valid=0.
  - A handshake (req_valid && req_ready) latches base, mode and shamt, sets x=0, y=0, and moves to RUN.
- State RUN:
  - req_ready=0; out_valid is registered and equals 1 throughout RUN.
  - First beat (x=0, y=0) is valid in the cycle after the request handshake (latency 1).
- Beat advance:
  - On out_valid && out_ready, x increments. When x wraps 4->0, y increments.
  - Order: x inner, y outer; 25 beats total.
  - The next beat is visible the following cycle, so back-to-back acceptance gives one beat per cycle.
- Stall: while out_valid && !out_ready, all outputs hold stable.
- Last beat: on acceptance of the beat with out_last=1, state returns to IDLE; out_valid=0 and req_ready=1 next cycle. A new request cannot be accepted in the same cycle as the last beat.
- Index per mode, all arithmetic on 0-4 values, mod 5 exact:
  - xy: idx = x + 5y
  - x1: idx = ((x+1) mod 5) + 5y
  - x2: idx = ((x+2) mod 5) + 5y
  - x4: idx = ((x+4) mod 5) + 5y
  - yx: idx = y + 5*((2x+3y) mod 5)
- Address: out_addr = (base + (idx << shamt)) mod 2^ADDR_W.
  - idx range is 0-24; the shifted value needs at most 5+2^SHAMT_W-1 bits, zero-extended.
  - out_addr is registered together with out_x and out_y.
- Abort:
  - Effective in any state; next cycle is IDLE with out_valid=0.
  - Abort has priority over both beat advance and a new request: a req_valid in the abort cycle is not accepted, and req_ready is forced to 0 in that cycle.
- out_ready is ignored while out_valid=0. req_* inputs are ignored outside the IDLE handshake, so changing them mid-sweep has no effect.
- Reset mid-sweep has the same effect as reset from any state; no further beats are produced.

Test Plan:
- Mode xy, base=0x1000, shamt=3, out_ready=1:
  - Exactly 25 beats on consecutive cycles: 0x1000, 0x1008, ..., 0x10C0.
  - out_last only on the beat at 0x10C0; req_ready=1 on the cycle after it.
- Mode yx, base=0, shamt=0, y=0 row:
  - Addresses 0, 10, 20, 5, 15.
  - Full sweep covers every value 0-24 exactly once.
- Mode x4, base=0, shamt=0:
  - First five beats 4, 0, 1, 2, 3.
  - Row y=4 gives 24, 20, 21, 22, 23.
- Backpressure:
  - Toggle out_ready with a pseudo-random pattern during a mode x1 sweep.
  - Outputs hold during stalls; sequence is unchanged; still exactly 25 handshakes.
- Abort and wrap-around:
  - Mode xy, base=0xFFFFFFF8, shamt=3: beat 2 is 0x00000000.
  - Abort after beat 3 together with req_valid=1: out_valid=0 next cycle and the request is not accepted.
  - A new request the following cycle restarts at (0,0).
- Reset mid-sweep: assert g_rst at beat 10 -> all outputs are reset values next cycle and req_ready=1 after reset deasserts.

Source files
------------

// File: rtl/xc_sha3_idx_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : xc_sha3_idx_seq_if
//  Brief    : Request / lane-address stream bundle for the SHA3 index sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface xc_sha3_idx_seq_if #(
    parameter int ADDR_W  = 32,
    parameter int SHAMT_W = 2
);
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_base;
    logic [2:0]         req_mode;
    logic [SHAMT_W-1:0] req_shamt;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_addr;
    logic [2:0]         out_x;
    logic [2:0]         out_y;
    logic               out_last;
    logic               busy;

    modport master (
        output req_valid, req_base, req_mode, req_shamt, abort, out_ready,
        input  req_ready, out_valid, out_addr, out_x, out_y, out_last, busy
    );

    modport slave (
        input  req_valid, req_base, req_mode, req_shamt, abort, out_ready,
        output req_ready, out_valid, out_addr, out_x, out_y, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/xc_sha3_idx_seq.sv
`default_nettype none
// ============================================================================
//  Module   : xc_sha3_idx_seq
//  Brief    : Sweeps all 25 Keccak lanes per request, emitting base+(idx<<shamt).
//  Revision : 1.0 - initial release
// ============================================================================
module xc_sha3_idx_seq #(
    parameter int ADDR_W  = 32,
    parameter int SHAMT_W = 2
) (
    input  wire logic          g_clk,
    input  wire logic          g_rst,
    xc_sha3_idx_seq_if.slave   bus
);
    localparam int c_SH_W = 5 + (2 ** SHAMT_W) - 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [2:0]         r_mode;
    logic [SHAMT_W-1:0] r_shamt;
    logic [2:0]         r_x;
    logic [2:0]         r_y;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_last;
    logic [2:0]         w_nx;
    logic [2:0]         w_ny;

    // Lane index for one (x,y) under the given mode, then shifted and added to base.
    function automatic logic [ADDR_W-1:0] f_addr(
        input logic [ADDR_W-1:0]  base,
        input logic [2:0]         mode,
        input logic [SHAMT_W-1:0] shamt,
        input logic [2:0]         x,
        input logic [2:0]         y
    );
        logic [3:0]        s;
        logic [4:0]        p;
        logic [4:0]        idx;
        logic [c_SH_W-1:0] sh;
        case (mode)
            3'd1:    s = {1'b0, x} + 4'd1;
            3'd2:    s = {1'b0, x} + 4'd2;
            3'd3:    s = {1'b0, x} + 4'd4;
            default: s = {1'b0, x};
        endcase
        if (s >= 4'd5) s = s - 4'd5;
        p = {1'b0, x, 1'b0} + {2'b00, y} + {1'b0, y, 1'b0};
        if (mode == 3'd4) idx = {2'b00, y} + (p % 5'd5) * 5'd5;
        else              idx = {1'b0, s} + {2'b00, y} * 5'd5;
        sh = c_SH_W'(idx) << shamt;
        return base + ADDR_W'(sh);
    endfunction

    always_comb begin
        w_nx = r_x + 3'd1;
        w_ny = r_y;
        if (r_x == 3'd4) begin
            w_nx = 3'd0;
            w_ny = r_y + 3'd1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_mode  <= '0;
            r_shamt <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_last  <= 1'b0;
        end else if (bus.abort) begin
            r_state <= S_IDLE;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_state <= S_RUN;
                        r_base  <= bus.req_base;
                        r_mode  <= bus.req_mode;
                        r_shamt <= bus.req_shamt;
                        r_x     <= 3'd0;
                        r_y     <= 3'd0;
                        r_addr  <= f_addr(bus.req_base, bus.req_mode, bus.req_shamt, 3'd0, 3'd0);
                        r_last  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.out_ready) begin
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_last  <= 1'b0;
                        end else begin
                            r_x    <= w_nx;
                            r_y    <= w_ny;
                            r_addr <= f_addr(r_base, r_mode, r_shamt, w_nx, w_ny);
                            r_last <= (w_nx == 3'd4) && (w_ny == 3'd4);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Abort blocks acceptance in the same cycle, hence the combinational gate.
    assign bus.req_ready = (r_state == S_IDLE) && !bus.abort;
    assign bus.out_valid = (r_state == S_RUN);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.out_addr  = r_addr;
    assign bus.out_x     = r_x;
    assign bus.out_y     = r_y;
    assign bus.out_last  = r_last;
endmodule
`default_nettype wire

// File: tb/tb_xc_sha3_idx_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xc_sha3_idx_seq
//  Brief    : Directed self-checking bench for the SHA3 lane-index sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xc_sha3_idx_seq;
    logic g_clk;
    logic g_rst;
    int   n_chk;
    int   n_fail;

    xc_sha3_idx_seq_if #(.ADDR_W(32), .SHAMT_W(2)) bus ();

    xc_sha3_idx_seq #(.ADDR_W(32), .SHAMT_W(2)) dut (
        .g_clk (g_clk),
        .g_rst (g_rst),
        .bus   (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] base, input logic [2:0] mode, input logic [1:0] shamt);
        bus.req_valid = 1'b1;
        bus.req_base  = base;
        bus.req_mode  = mode;
        bus.req_shamt = shamt;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset;
        g_rst = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.out_x, bus.out_y, bus.out_addr} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b x=%0d y=%0d a=%h, want all zero",
                     bus.out_valid, bus.out_last, bus.busy, bus.out_x, bus.out_y, bus.out_addr);
        end
        g_rst = 1'b0;
        tick();
        n_chk++;
        if ({bus.req_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b valid=%b, want ready=1 valid=0", bus.req_ready, bus.out_valid);
        end
    endtask

    task automatic test_xy_sweep;
        logic [39:0] got, exp;
        bus.out_ready = 1'b1;
        do_req(32'h1000, 3'd0, 2'd3);
        n_chk++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL xy_ready_in_run: got %b want 0", bus.req_ready);
        end
        for (int i = 0; i < 25; i++) begin
            got = {bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.out_addr};
            exp = {1'b1, 3'(i % 5), 3'(i / 5), (i == 24), 32'h1000 + 32'(i * 8)};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL xy_beat%0d: got %h want %h", i, got, exp);
            end
            if (i == 24) bus.req_valid = 1'b1;
            tick();
        end
        n_chk++;
        if ({bus.out_valid, bus.req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL xy_after_last: got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.req_ready);
        end
        bus.req_valid = 1'b0;
        tick();
    endtask

    task automatic test_yx;
        int          tab[25] = '{0, 10, 20, 5, 15, 16, 1, 11, 21, 6, 7, 17, 2, 12, 22,
                                 23, 8, 18, 3, 13, 14, 24, 9, 19, 4};
        logic [24:0] seen;
        logic [32:0] got, exp;
        seen = '0;
        bus.out_ready = 1'b1;
        do_req(32'h0, 3'd4, 2'd0);
        for (int i = 0; i < 25; i++) begin
            got = {bus.out_valid, bus.out_addr};
            exp = {1'b1, 32'(tab[i])};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL yx_beat%0d: got %h want %h", i, got, exp);
            end
            if (bus.out_addr < 32'd25) seen[bus.out_addr[4:0]] = 1'b1;
            tick();
        end
        n_chk++;
        if (seen !== 25'h1FF_FFFF) begin
            n_fail++;
            $display("FAIL yx_coverage: got %h want 1ffffff", seen);
        end
        tick();
    endtask

    task automatic test_x4;
        int          row[5] = '{4, 0, 1, 2, 3};
        logic [39:0] got, exp;
        bus.out_ready = 1'b1;
        do_req(32'h0, 3'd3, 2'd0);
        for (int i = 0; i < 25; i++) begin
            got = {bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.out_addr};
            exp = {1'b1, 3'(i % 5), 3'(i / 5), (i == 24), 32'(row[i % 5] + 5 * (i / 5))};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL x4_beat%0d: got %h want %h", i, got, exp);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_backpressure;
        int          row[5] = '{1, 2, 3, 4, 0};
        logic [7:0]  lfsr;
        logic [39:0] got, exp;
        int          k, cyc;
        lfsr = 8'hA5;
        k = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        do_req(32'h200, 3'd1, 2'd2);
        while (k < 25 && cyc < 300) begin
            got = {bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.out_addr};
            exp = {1'b1, 3'(k % 5), 3'(k / 5), (k == 24),
                   32'h200 + 32'((row[k % 5] + 5 * (k / 5)) * 4)};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bp_beat%0d_cyc%0d: got %h want %h", k, cyc, got, exp);
            end
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus.out_ready = lfsr[0];
            bus.req_valid = 1'b1;
            bus.req_base  = 32'hDEAD_0000 + 32'(cyc);
            bus.req_mode  = 3'd4;
            tick();
            if (bus.out_ready) k++;
            cyc++;
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_chk++;
        if (k !== 25 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_handshakes: got %0d beats valid=%b want 25 beats valid=0", k, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_abort_wrap;
        logic [39:0] got, exp;
        bus.out_ready = 1'b1;
        do_req(32'hFFFF_FFF8, 3'd0, 2'd3);
        for (int i = 0; i < 3; i++) begin
            got = {bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.out_addr};
            exp = {1'b1, 3'(i), 3'd0, 1'b0, 32'hFFFF_FFF8 + 32'(i * 8)};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: got %h want %h", i, got, exp);
            end
            tick();
        end
        bus.abort     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_base  = 32'h40;
        bus.req_mode  = 3'd0;
        bus.req_shamt = 2'd0;
        #1;
        n_chk++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready: got %b want 0", bus.req_ready);
        end
        tick();
        bus.abort = 1'b0;
        #1;
        n_chk++;
        if ({bus.out_valid, bus.busy, bus.req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_idle: got valid=%b busy=%b ready=%b want 0 0 1",
                     bus.out_valid, bus.busy, bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        n_chk++;
        if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_addr} !== {1'b1, 3'd0, 3'd0, 32'h40}) begin
            n_fail++;
            $display("FAIL abort_restart: got v=%b x=%0d y=%0d a=%h want v=1 x=0 y=0 a=40",
                     bus.out_valid, bus.out_x, bus.out_y, bus.out_addr);
        end
        tick();
        n_chk++;
        if ({bus.out_x, bus.out_addr} !== {3'd1, 32'h41}) begin
            n_fail++;
            $display("FAIL abort_restart_b1: got x=%0d a=%h want x=1 a=41", bus.out_x, bus.out_addr);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_second: got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b1;
        do_req(32'h0, 3'd2, 2'd1);
        repeat (10) tick();
        n_chk++;
        if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_addr} !== {1'b1, 3'd0, 3'd2, 32'd24}) begin
            n_fail++;
            $display("FAIL x2_beat10: got v=%b x=%0d y=%0d a=%h want v=1 x=0 y=2 a=18",
                     bus.out_valid, bus.out_x, bus.out_y, bus.out_addr);
        end
        g_rst = 1'b1;
        tick();
        n_chk++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.out_x, bus.out_y, bus.out_addr} !== 41'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got v=%b l=%b b=%b x=%0d y=%0d a=%h want all zero",
                     bus.out_valid, bus.out_last, bus.busy, bus.out_x, bus.out_y, bus.out_addr);
        end
        g_rst = 1'b0;
        #1;
        n_chk++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b want 1", bus.req_ready);
        end
        repeat (3) tick();
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_beats: got valid=%b want 0", bus.out_valid);
        end
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        g_rst         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_base  = '0;
        bus.req_mode  = '0;
        bus.req_shamt = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_xy_sweep();
        test_yx();
        test_x4();
        test_backpressure();
        test_abort_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
